// File: rtl/alu_writeback.sv
// alu_writeback: consumer end of the ALU result interface. Detects each toggle of
//   alu_signal, captures the result bundle, and retires it to the register file
//   (ADD/SUB/MUL), the branch flag (BEQ) or the PC (BNZ).
// Latency: toggle seen at edge N -> rf_we/pc_load high in the cycle after edge N;
//   minimum two cycles per retirement (state cycle + IDLE cycle).
// Backpressure: WRITE holds until rf_ready; one further result is parked in a
//   one-deep pending slot, anything beyond that is dropped and flagged (drop_err).
//
// Ports:
//   clock, reset        core clock, synchronous active-high reset
//   alu_signal          completion toggle; every level change is one new result
//   alu_solution/_overflow/_jump, op, rd
//                       result bundle and issued op, sampled on the toggle edge
//   rf_ready            register file accepts the write this cycle
//   rf_we/rf_waddr/rf_wdata   register-file write request
//   beq_flag            last BEQ compare result
//   pc_load/pc_value    one-cycle PC load strobe and value
//   ovf_flag            overflow of last retired ADD/SUB/MUL
//   busy                FSM not idle or pending slot occupied
//   illegal_op          one-cycle pulse for an undefined opcode
//   drop_err            sticky: a result was lost to a full pending slot
//   retired             wrapping count of retired results

module alu_writeback #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alu_signal,
  input  logic [DATA_W-1:0]  alu_solution,
  input  logic               alu_overflow,
  input  logic [DATA_W-1:0]  alu_jump,
  input  logic [2:0]         op,
  input  logic [RADDR_W-1:0] rd,
  input  logic               rf_ready,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               beq_flag,
  output logic               pc_load,
  output logic [DATA_W-1:0]  pc_value,
  output logic               ovf_flag,
  output logic               busy,
  output logic               illegal_op,
  output logic               drop_err,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FLAG   = 2'd2,
    ST_BRANCH = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_BNZ = 3'b111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic                 sig_q;

  // Working registers: the result currently being retired.
  logic [2:0]           w_op_q, w_op_d;
  logic [RADDR_W-1:0]   w_rd_q, w_rd_d;
  logic [DATA_W-1:0]    w_sol_q, w_sol_d;
  logic                 w_ovf_q, w_ovf_d;
  logic [DATA_W-1:0]    w_jump_q, w_jump_d;

  // One-deep pending slot.
  logic                 s_vld_q, s_vld_d;
  logic [2:0]           s_op_q, s_op_d;
  logic [RADDR_W-1:0]   s_rd_q, s_rd_d;
  logic [DATA_W-1:0]    s_sol_q, s_sol_d;
  logic                 s_ovf_q, s_ovf_d;
  logic [DATA_W-1:0]    s_jump_q, s_jump_d;

  // Architectural flags and counters.
  logic                 beq_q, beq_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;
  logic                 ill_q, ill_d;
  logic [CNT_W-1:0]     ret_q, ret_d;

  // ---------------------------------------------------------------------------
  // Event detection and capture routing
  // ---------------------------------------------------------------------------
  logic                 evt;
  logic                 is_idle;
  logic                 src_from_slot;
  logic                 src_from_evt;
  logic                 src_vld;
  logic [2:0]           src_op;
  logic [RADDR_W-1:0]   src_rd;
  logic [DATA_W-1:0]    src_sol;
  logic                 src_ovf;
  logic [DATA_W-1:0]    src_jump;
  logic                 slot_take;
  logic                 slot_room;
  logic                 drop_now;
  logic                 src_illegal;
  logic                 wr_accept;
  logic                 retire;

  assign evt     = alu_signal ^ sig_q;
  assign is_idle = (state_q == ST_IDLE);

  // In IDLE a parked result always goes first; a fresh event is only taken
  // straight into the working registers when nothing is waiting ahead of it.
  assign src_from_slot = is_idle && s_vld_q;
  assign src_from_evt  = is_idle && !s_vld_q && evt;
  assign src_vld       = src_from_slot || src_from_evt;

  always_comb begin
    src_op   = op;
    src_rd   = rd;
    src_sol  = alu_solution;
    src_ovf  = alu_overflow;
    src_jump = alu_jump;
    if (s_vld_q) begin
      src_op   = s_op_q;
      src_rd   = s_rd_q;
      src_sol  = s_sol_q;
      src_ovf  = s_ovf_q;
      src_jump = s_jump_q;
    end
  end

  // Any event not taken directly must be parked. The slot has room if it is
  // empty or is being drained into the working registers on this same edge.
  assign slot_take = evt && !src_from_evt;
  assign slot_room = !s_vld_q || src_from_slot;
  assign drop_now  = slot_take && !slot_room;

  always_comb begin
    src_illegal = 1'b1;
    case (src_op)
      OP_ADD, OP_SUB, OP_MUL, OP_BEQ, OP_BNZ: src_illegal = 1'b0;
      default:                                src_illegal = 1'b1;
    endcase
  end

  assign wr_accept = (state_q == ST_WRITE) && rf_ready;
  assign retire    = wr_accept || (state_q == ST_FLAG) || (state_q == ST_BRANCH);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (src_vld) begin
          case (src_op)
            OP_ADD, OP_SUB, OP_MUL: state_d = ST_WRITE;
            OP_BEQ:                 state_d = ST_FLAG;
            OP_BNZ:                 state_d = ST_BRANCH;
            default:                state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE:  if (rf_ready) state_d = ST_IDLE;
      ST_FLAG:   state_d = ST_IDLE;
      ST_BRANCH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Address/data buses are zeroed outside their strobe so the interface is
  // quiet while idle and after reset.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    pc_load  = 1'b0;
    pc_value = '0;
    case (state_q)
      ST_WRITE: begin
        rf_we    = 1'b1;
        rf_waddr = w_rd_q;
        rf_wdata = w_sol_q;
      end
      ST_BRANCH: begin
        pc_load  = 1'b1;
        pc_value = w_jump_q;
      end
      default: ;
    endcase
  end

  assign busy       = !is_idle || s_vld_q;
  assign beq_flag   = beq_q;
  assign ovf_flag   = ovf_q;
  assign drop_err   = drop_q;
  assign illegal_op = ill_q;
  assign retired    = ret_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_op_d   = w_op_q;
    w_rd_d   = w_rd_q;
    w_sol_d  = w_sol_q;
    w_ovf_d  = w_ovf_q;
    w_jump_d = w_jump_q;
    if (src_vld) begin
      w_op_d   = src_op;
      w_rd_d   = src_rd;
      w_sol_d  = src_sol;
      w_ovf_d  = src_ovf;
      w_jump_d = src_jump;
    end
  end

  always_comb begin
    s_vld_d  = s_vld_q;
    s_op_d   = s_op_q;
    s_rd_d   = s_rd_q;
    s_sol_d  = s_sol_q;
    s_ovf_d  = s_ovf_q;
    s_jump_d = s_jump_q;
    if (src_from_slot) begin
      s_vld_d = 1'b0;
    end
    if (slot_take && slot_room) begin
      s_vld_d  = 1'b1;
      s_op_d   = op;
      s_rd_d   = rd;
      s_sol_d  = alu_solution;
      s_ovf_d  = alu_overflow;
      s_jump_d = alu_jump;
    end
  end

  always_comb begin
    beq_d  = beq_q;
    ovf_d  = ovf_q;
    drop_d = drop_q || drop_now;
    ill_d  = src_vld && src_illegal;
    ret_d  = ret_q + CNT_W'(retire);
    if (state_q == ST_FLAG) begin
      beq_d = (w_sol_q == DATA_W'(1));
    end
    if (wr_accept) begin
      ovf_d = w_ovf_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q    <= 1'b0;
      w_op_q   <= '0;
      w_rd_q   <= '0;
      w_sol_q  <= '0;
      w_ovf_q  <= 1'b0;
      w_jump_q <= '0;
      s_vld_q  <= 1'b0;
      s_op_q   <= '0;
      s_rd_q   <= '0;
      s_sol_q  <= '0;
      s_ovf_q  <= 1'b0;
      s_jump_q <= '0;
      beq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      ill_q    <= 1'b0;
      ret_q    <= '0;
    end else begin
      sig_q    <= alu_signal;
      w_op_q   <= w_op_d;
      w_rd_q   <= w_rd_d;
      w_sol_q  <= w_sol_d;
      w_ovf_q  <= w_ovf_d;
      w_jump_q <= w_jump_d;
      s_vld_q  <= s_vld_d;
      s_op_q   <= s_op_d;
      s_rd_q   <= s_rd_d;
      s_sol_q  <= s_sol_d;
      s_ovf_q  <= s_ovf_d;
      s_jump_q <= s_jump_d;
      beq_q    <= beq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      ill_q    <= ill_d;
      ret_q    <= ret_d;
    end
  end

endmodule
